pcie_tx_scheduler: RTL and testbench

//  Sequences the PHY TX block-source mux. Arbitrates among TLP, DLLP and ordered-set

---
 rtl/pcie_tx_scheduler.sv | 73 +++++++
 tb/tb_pcie_tx_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_scheduler.sv
// pcie_tx_scheduler: arbitrates TLP/DLLP/OS blocks onto the PHY TX mux with periodic SKP insertion
module pcie_tx_scheduler #(
  parameter int DATA_WIDTH = 128,
  parameter int SKP_INTERVAL = 370,
  parameter int MAX_DLLP_RUN = 4,
  parameter logic [DATA_WIDTH-1:0] SKP_PATTERN = {(DATA_WIDTH/8){8'hAA}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  link_up,
  input  logic                  tlp_valid,
  input  logic                  tlp_last,
  input  logic [DATA_WIDTH-1:0] tlp_data,
  output logic                  tlp_ready,
  input  logic                  dllp_valid,
  input  logic [DATA_WIDTH-1:0] dllp_data,
  output logic                  dllp_ready,
  input  logic                  os_valid,
  input  logic [DATA_WIDTH-1:0] os_data,
  output logic                  os_ready,
  output logic [1:0]            out_sel,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  skp_active
);
  localparam int CW = $clog2(SKP_INTERVAL);
  localparam int RW = $clog2(MAX_DLLP_RUN + 1);
  typedef enum logic {ARB, TLP} state_t;
  state_t state, state_n;
  logic [CW-1:0] skp_cnt;
  logic [RW-1:0] dllp_run;
  logic skp_pending, arb, skp_go, dllp_ok, wrap, en;
  always_ff @(posedge clk)
    state <= reset ? ARB : state_n;
  always_comb
    state_n = !link_up ? ARB : tlp_ready ? (tlp_last ? ARB : TLP) : state;
  // readies carry the valid, so ready doubles as the grant/transfer strobe
  always_comb begin
    en = !reset && link_up;
    arb = state == ARB;
    wrap = skp_cnt == CW'(SKP_INTERVAL - 1);
    skp_go = en && arb && skp_pending;
    dllp_ok = !(dllp_run == RW'(MAX_DLLP_RUN) && tlp_valid);
    os_ready = en && arb && !skp_pending && os_valid;
    dllp_ready = en && arb && !skp_pending && !os_valid && dllp_valid && dllp_ok;
    tlp_ready = en && tlp_valid && (!arb || (!skp_pending && !os_valid && !(dllp_valid && dllp_ok)));
  end
  // a wrap that lands while an SKP is still owed does not queue a second one
  always_ff @(posedge clk)
    if (reset || !link_up) begin
      skp_cnt <= '0;
      skp_pending <= 1'b0;
      dllp_run <= '0;
    end else begin
      skp_cnt <= wrap ? '0 : skp_cnt + CW'(1);
      skp_pending <= skp_go ? 1'b0 : (skp_pending || wrap);
      dllp_run <= tlp_ready ? '0 :
                  (dllp_ready && tlp_valid && dllp_run != RW'(MAX_DLLP_RUN)) ? dllp_run + RW'(1) : dllp_run;
    end
  always_ff @(posedge clk)
    if (reset) begin
      out_sel <= 2'b11;
      out_data <= '0;
      out_valid <= 1'b0;
      skp_active <= 1'b0;
    end else begin
      out_sel <= (skp_go || os_ready) ? 2'b10 : dllp_ready ? 2'b01 : tlp_ready ? 2'b00 : 2'b11;
      out_data <= skp_go ? SKP_PATTERN : os_ready ? os_data : dllp_ready ? dllp_data :
                  tlp_ready ? tlp_data : '0;
      out_valid <= skp_go || os_ready || dllp_ready || tlp_ready;
      skp_active <= skp_go;
    end
endmodule

// File: tb/tb_pcie_tx_scheduler.sv
// tb_pcie_tx_scheduler: directed scoreboard bench for pcie_tx_scheduler
module tb_pcie_tx_scheduler;
  logic clk = 0, reset = 1, link_up = 1;
  logic tlp_valid = 0, tlp_last = 0, dllp_valid = 0, os_valid = 0;
  logic [127:0] tlp_data = 0, dllp_data = 0, os_data = 0, out_data;
  logic tlp_ready, dllp_ready, os_ready, out_valid, skp_active;
  logic [1:0] out_sel;
  logic [130:0] exp_q[$];
  int total = 0, bad = 0;
  localparam logic [127:0] SKP = {16{8'hAA}};
  localparam logic [1:0] S_TLP = 2'b00, S_DLLP = 2'b01, S_OS = 2'b10, S_IDLE = 2'b11;

  pcie_tx_scheduler dut (
    .clk(clk), .reset(reset), .link_up(link_up),
    .tlp_valid(tlp_valid), .tlp_last(tlp_last), .tlp_data(tlp_data), .tlp_ready(tlp_ready),
    .dllp_valid(dllp_valid), .dllp_data(dllp_data), .dllp_ready(dllp_ready),
    .os_valid(os_valid), .os_data(os_data), .os_ready(os_ready),
    .out_sel(out_sel), .out_data(out_data), .out_valid(out_valid), .skp_active(skp_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [1:0] s, input logic [127:0] d, input logic k);
    logic [130:0] e;
    exp_q.push_back({s, d, k});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("out_sel", 128'(out_sel), 128'(e[130:129]));
    chk("out_data", out_data, e[128:1]);
    chk("out_valid", 128'(out_valid), 128'(e[130:129] != S_IDLE));
    chk("skp_active", 128'(skp_active), 128'(e[0]));
  endtask

  task automatic idle();
    tick(S_IDLE, '0, 1'b0);
  endtask

  task automatic link_cycle();
    link_up = 0;
    idle();
    link_up = 1;
  endtask

  initial begin
    tlp_valid = 1; dllp_valid = 1; os_valid = 1;
    #1;
    chk("rst_tlp_ready", 128'(tlp_ready), 0);
    chk("rst_dllp_ready", 128'(dllp_ready), 0);
    chk("rst_os_ready", 128'(os_ready), 0);
    idle();
    tlp_valid = 0; dllp_valid = 0; os_valid = 0;
    reset = 0;
    // first SKP lands on the 371st output slot after reset release
    for (int i = 1; i <= 370; i++) idle();
    tick(S_OS, SKP, 1'b1);
    idle();

    // 3-beat TLP with a DLLP raised after beat 0
    link_cycle();
    tlp_valid = 1; tlp_last = 0; tlp_data = 128'hD0;
    #1 chk("t2_ready0", 128'(tlp_ready), 1);
    tick(S_TLP, 128'hD0, 0);
    tlp_data = 128'hD1; dllp_valid = 1; dllp_data = 128'h1111;
    #1 chk("t2_dllp_blocked", 128'(dllp_ready), 0);
    tick(S_TLP, 128'hD1, 0);
    tlp_data = 128'hD2; tlp_last = 1;
    tick(S_TLP, 128'hD2, 0);
    tlp_valid = 0; tlp_last = 0;
    #1 chk("t2_dllp_ready", 128'(dllp_ready), 1);
    tick(S_DLLP, 128'h1111, 0);
    dllp_valid = 0;
    idle();

    // DLLP starvation limit
    link_cycle();
    dllp_valid = 1; dllp_data = 128'h2222; tlp_valid = 1; tlp_last = 1; tlp_data = 128'hE0;
    for (int i = 0; i < 4; i++) tick(S_DLLP, 128'h2222, 0);
    #1 chk("t3_tlp_ready", 128'(tlp_ready), 1);
    tick(S_TLP, 128'hE0, 0);
    tick(S_DLLP, 128'h2222, 0);
    dllp_valid = 0; tlp_valid = 0; tlp_last = 0;
    idle();

    // OS beats DLLP and TLP when all are offered in ARB
    link_cycle();
    os_valid = 1; os_data = 128'h0505; dllp_valid = 1; tlp_valid = 1; tlp_last = 1;
    #1 chk("pri_dllp_ready", 128'(dllp_ready), 0);
    chk("pri_tlp_ready", 128'(tlp_ready), 0);
    tick(S_OS, 128'h0505, 0);
    os_valid = 0; dllp_valid = 0; tlp_valid = 0; tlp_last = 0;
    idle();

    // SKP due mid-packet waits for the last beat, then precedes a pending OS
    link_cycle();
    for (int i = 1; i <= 368; i++) idle();
    tlp_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tlp_last = (i == 3);
      tlp_data = 128'hF0 + 128'(i);
      tick(S_TLP, 128'hF0 + 128'(i), 0);
    end
    tlp_valid = 0; tlp_last = 0;
    os_valid = 1; os_data = 128'h0707;
    #1 chk("t4_os_wait", 128'(os_ready), 0);
    tick(S_OS, SKP, 1);
    #1 chk("t4_os_ready", 128'(os_ready), 1);
    tick(S_OS, 128'h0707, 0);
    os_valid = 0;
    idle();

    // link drop mid-packet abandons it
    link_cycle();
    tlp_valid = 1; tlp_last = 0;
    tlp_data = 128'hA0; tick(S_TLP, 128'hA0, 0);
    tlp_data = 128'hA1; tick(S_TLP, 128'hA1, 0);
    link_up = 0; tlp_data = 128'hA2;
    #1 chk("t5_ready_down", 128'(tlp_ready), 0);
    idle();
    link_up = 1; dllp_valid = 1; dllp_data = 128'h3333; tlp_data = 128'hB0;
    tick(S_DLLP, 128'h3333, 0);
    dllp_valid = 0;
    tick(S_TLP, 128'hB0, 0);
    tlp_last = 1; tlp_data = 128'hB1;
    tick(S_TLP, 128'hB1, 0);
    tlp_valid = 0; tlp_last = 0;
    idle();

    // back-to-back single-beat TLPs
    link_cycle();
    tlp_valid = 1; tlp_last = 1;
    for (int i = 0; i < 4; i++) begin
      tlp_data = 128'hC0 + 128'(i);
      tick(S_TLP, 128'hC0 + 128'(i), 0);
    end
    tlp_valid = 0; tlp_last = 0;
    idle();

    // reset mid-packet returns to ARB with reset outputs
    link_cycle();
    tlp_valid = 1; tlp_last = 0; tlp_data = 128'h99;
    tick(S_TLP, 128'h99, 0);
    reset = 1;
    #1 chk("rst_mid_ready", 128'(tlp_ready), 0);
    idle();
    reset = 0; dllp_valid = 1; dllp_data = 128'h4444;
    tick(S_DLLP, 128'h4444, 0);
    dllp_valid = 0; tlp_valid = 0;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
